// File: rtl/pci_pkg.sv
// Shared definitions for the central PCI bus arbiter.
package pci_pkg;

    // Index width wide enough for the largest supported master count (8).
    localparam int IDX_W = 3;

    localparam logic [1:0] PARK   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] BUSY   = 2'd2;
    localparam logic [1:0] SWITCH = 2'd3;

    function automatic logic bus_idle(
        input logic frame,
        input logic irdy
    );
        return frame & irdy;
    endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Arbiter-facing PCI bus bundle: request/grant lines and shared bus sense.
interface pci_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic                   frame;
    logic                   irdy;
    logic [NUM_MASTERS-1:0] gnt;
    logic [W-1:0]           owner;
    logic                   busy;

    modport master (
        input  req, frame, irdy,
        output gnt, owner, busy
    );

    modport slave (
        output req, frame, irdy,
        input  gnt, owner, busy
    );

endinterface

// File: rtl/pci_rr_picker.sv
// Round-robin winner select over active-low requests, starting after ptr.
module pci_rr_picker
    import pci_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
    output logic [$clog2(NUM_MASTERS)-1:0] winner,
    output logic                           valid
);
    localparam int W  = $clog2(NUM_MASTERS);
    localparam int JW = IDX_W + 1;

    // Scan from farthest to nearest so the nearest requester wins last.
    always_comb begin
        logic [JW-1:0] j;
        logic [W-1:0]  cand;
        winner = '0;
        valid  = 1'b0;
        j      = '0;
        cand   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            j = JW'(ptr) + JW'(i);
            if (j >= JW'(NUM_MASTERS)) begin
                j = j - JW'(NUM_MASTERS);
            end
            cand = W'(j);
            if (!req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grants, bus parking, unused-grant
// timeout and hidden-arbitration preemption of the current owner.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16,
    parameter int PARK_MASTER = 0
) (
    input logic               clk,
    input logic               rst,
    pci_bus_arbiter_if.master bus
);
    localparam int W  = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [W-1:0]  PARK_IDX = W'(PARK_MASTER);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [W-1:0]           owner_q, owner_d;
    logic [W-1:0]           ptr_q, ptr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   preempt_q, preempt_d;

    logic [W-1:0]           winner;
    logic                   win_vld;
    logic                   idle;
    logic [NUM_MASTERS-1:0] others;

    pci_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .winner(winner),
        .valid (win_vld)
    );

    assign idle = bus_idle(bus.frame, bus.irdy);

    always_comb begin
        others         = ~bus.req;
        others[owner_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        preempt_d = 1'b0;
        case (state_q)
            PARK: begin
                owner_d = PARK_IDX;
                if (!bus.frame) begin
                    state_d = BUSY;
                end else if (win_vld && winner == PARK_IDX) begin
                    state_d = GRANT;
                    timer_d = '0;
                end else if (win_vld) begin
                    state_d = SWITCH;
                end
            end
            GRANT: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                if (!bus.frame) begin
                    state_d = BUSY;
                    timer_d = '0;
                    ptr_d   = owner_q;
                end else if (bus.req[owner_q]) begin
                    state_d = SWITCH;
                end else if (timer_q >= T_LAST && idle) begin
                    state_d = SWITCH;
                    ptr_d   = owner_q;
                end
            end
            BUSY: begin
                preempt_d = preempt_q | (|others);
                // Handing the parked grant to a different master still
                // goes through a turnaround cycle.
                if (idle) begin
                    if (preempt_d) begin
                        state_d = SWITCH;
                    end else if (!bus.req[owner_q]) begin
                        state_d = GRANT;
                        timer_d = '0;
                    end else if (owner_q == PARK_IDX) begin
                        state_d = PARK;
                    end else begin
                        state_d = SWITCH;
                    end
                end
            end
            default: begin
                if (idle) begin
                    if (win_vld) begin
                        state_d = GRANT;
                        owner_d = winner;
                        timer_d = '0;
                    end else begin
                        state_d = PARK;
                        owner_d = PARK_IDX;
                    end
                end
            end
        endcase
        if (state_d != BUSY) begin
            preempt_d = 1'b0;
        end
    end

    always_comb begin
        gnt_d  = '1;
        busy_d = (state_d == BUSY);
        case (state_d)
            PARK:  gnt_d[PARK_IDX] = 1'b0;
            GRANT: gnt_d[owner_d]  = 1'b0;
            BUSY: begin
                if (!preempt_d) begin
                    gnt_d[owner_d] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SWITCH;
            owner_q   <= PARK_IDX;
            ptr_q     <= PARK_IDX;
            timer_q   <= '0;
            gnt_q     <= '1;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed scoreboard bench for pci_bus_arbiter (4 masters, park on 0).
module tb_pci_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [3:0] prev_g = 4'hF;

    typedef struct {
        int         at;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        string      nm;
    } exp_t;

    exp_t sb[$];

    pci_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

    pci_bus_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT    (16),
        .PARK_MASTER(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_in(
        input int         d,
        input logic [3:0] g,
        input logic [1:0] o,
        input logic       b,
        input string      nm
    );
        exp_t e;
        e.at = cyc + d;
        e.g  = g;
        e.o  = o;
        e.b  = b;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops due expectations and checks bus-wide invariants.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                total++;
                if (bus.gnt !== sb[i].g || bus.owner !== sb[i].o ||
                    bus.busy !== sb[i].b) begin
                    bad++;
                    $display("FAIL %s: gnt=%b owner=%0d busy=%b want gnt=%b owner=%0d busy=%b",
                             sb[i].nm, bus.gnt, bus.owner, bus.busy,
                             sb[i].g, sb[i].o, sb[i].b);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check missed at cycle %0d", sb[i].nm, cyc);
                sb.delete(i);
            end
        end
        total++;
        if ($countones(~bus.gnt) > 1) begin
            bad++;
            $display("FAIL onehot: gnt=%b want at most one low", bus.gnt);
        end
        if (prev_g != 4'hF && bus.gnt != 4'hF) begin
            total++;
            if (prev_g != bus.gnt) begin
                bad++;
                $display("FAIL turnaround: gnt=%b after %b want all-high between",
                         bus.gnt, prev_g);
            end
        end
        prev_g = bus.gnt;
    end

    initial begin
        bus.req   = 4'hF;
        bus.frame = 1'b1;
        bus.irdy  = 1'b1;

        // Reset and park on master 0.
        step(1);
        expect_in(1, 4'hF, 2'd0, 1'b0, "in_rst");
        step(1);
        rst = 1'b0;
        expect_in(1, 4'hE, 2'd0, 1'b0, "park0");
        step(1);

        // Master 1 requests while parked.
        bus.req = 4'b1101;
        expect_in(1, 4'hF, 2'd0, 1'b0, "sw_to1");
        expect_in(2, 4'hD, 2'd1, 1'b0, "gnt1");
        step(2);
        bus.frame = 1'b0;
        expect_in(1, 4'hD, 2'd1, 1'b1, "busy1");
        step(1);

        // Master 2 waits: preempt, sticky, then handover on idle.
        bus.req  = 4'b1011;
        bus.irdy = 1'b0;
        expect_in(1, 4'hF, 2'd1, 1'b1, "preempt");
        step(1);
        bus.req = 4'hF;
        expect_in(1, 4'hF, 2'd1, 1'b1, "sticky");
        step(1);
        bus.frame = 1'b1;
        bus.req   = 4'b1011;
        expect_in(1, 4'hF, 2'd1, 1'b1, "last_data");
        step(1);
        bus.irdy = 1'b1;
        expect_in(1, 4'hF, 2'd1, 1'b0, "sw_to2");
        expect_in(2, 4'hB, 2'd2, 1'b0, "gnt2");
        step(2);

        // Master 2 never starts: timeout, then master 3 (2 skipped).
        bus.req = 4'b0011;
        expect_in(15, 4'hB, 2'd2, 1'b0, "pre_timeout");
        expect_in(16, 4'hF, 2'd2, 1'b0, "timeout");
        expect_in(17, 4'h7, 2'd3, 1'b0, "gnt3_skip2");
        step(17);

        // Owner drops req unused: turnaround then park.
        bus.req = 4'hF;
        expect_in(1, 4'hF, 2'd3, 1'b0, "drop3");
        expect_in(2, 4'hE, 2'd0, 1'b0, "park_again");
        step(2);

        // Parked master 0 starts a burst without req, then async reset.
        bus.frame = 1'b0;
        bus.irdy  = 1'b0;
        expect_in(1, 4'hE, 2'd0, 1'b1, "park_busy");
        step(1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_in(0, 4'hF, 2'd0, 1'b0, "async_rst");
        step(1);

        // Burst still running: no grant until the bus goes idle.
        rst     = 1'b0;
        bus.req = 4'b0101;
        expect_in(1, 4'hF, 2'd0, 1'b0, "sw_hold");
        step(1);
        bus.frame = 1'b1;
        expect_in(1, 4'hF, 2'd0, 1'b0, "sw_irdy");
        step(1);
        bus.irdy = 1'b1;
        expect_in(1, 4'hD, 2'd1, 1'b0, "rr_first1");
        step(1);

        // Master 1 transfers, master 3 waiting preempts it.
        bus.frame = 1'b0;
        expect_in(1, 4'hD, 2'd1, 1'b1, "busy1b");
        step(1);
        bus.req = 4'b0111;
        expect_in(1, 4'hF, 2'd1, 1'b1, "pre_by3");
        step(1);
        bus.frame = 1'b1;
        expect_in(1, 4'hF, 2'd1, 1'b0, "sw_to3");
        expect_in(2, 4'h7, 2'd3, 1'b0, "gnt3");
        step(2);
        bus.frame = 1'b0;
        expect_in(1, 4'h7, 2'd3, 1'b1, "busy3");
        step(1);

        // Owner 3 done, nobody waiting: turnaround into park.
        bus.req   = 4'hF;
        bus.frame = 1'b1;
        expect_in(1, 4'hF, 2'd3, 1'b0, "end3");
        expect_in(2, 4'hE, 2'd0, 1'b0, "park3");
        step(2);

        // Pointer at 3: masters 1 and 2 both ask, 1 is nearer.
        bus.req = 4'b1001;
        expect_in(1, 4'hF, 2'd0, 1'b0, "sw_ptr");
        expect_in(2, 4'hD, 2'd1, 1'b0, "ptr_is3");
        step(2);

        // Owner still requesting at idle keeps its grant.
        bus.req   = 4'b1101;
        bus.frame = 1'b0;
        expect_in(1, 4'hD, 2'd1, 1'b1, "busy1c");
        step(1);
        bus.frame = 1'b1;
        expect_in(1, 4'hD, 2'd1, 1'b0, "regrant1");
        step(1);
        bus.req = 4'hF;
        expect_in(1, 4'hF, 2'd1, 1'b0, "drop1");
        expect_in(2, 4'hE, 2'd0, 1'b0, "park_end");
        step(3);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
